// File: rtl/rev_pkg.sv
// Shared word width and lane-select encoding for the 12-bit stream demux.
package rev_pkg;

    localparam int unsigned WORD_W = 12;

    typedef enum logic {
        LANE_A = 1'b0,
        LANE_B = 1'b1
    } lane_e;

endpackage : rev_pkg

// File: rtl/lane_fifo.sv
// Synchronous FIFO for one demux lane; level is an explicit counter, pointers wrap mod DEPTH.
module lane_fifo
    import rev_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    // Head is masked to zero while empty so stale storage never leaks out.
    assign dout  = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        push_ok_c = push && !full;
        pop_ok_c  = pop && !empty;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        if (push_ok_c) wptr_d = wptr_q + PW'(1);
        if (pop_ok_c)  rptr_d = rptr_q + PW'(1);
        case ({push_ok_c, pop_ok_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            if (push_ok_c) mem_q[wptr_q] <= din;
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule : lane_fifo

// File: rtl/demux12bit_stream.sv
// 1-to-2 word demux: steers each accepted word into lane A or B by in_sel.
module demux12bit_stream
    import rev_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           a_data,
    output logic                       a_valid,
    input  logic                       a_ready,
    output logic [WIDTH-1:0]           b_data,
    output logic                       b_valid,
    input  logic                       b_ready,
    output logic [$clog2(DEPTH):0]     a_level,
    output logic [$clog2(DEPTH):0]     b_level
);

    lane_e sel_c;
    logic  a_full, b_full;
    logic  a_empty, b_empty;
    logic  push_a_c, push_b_c;
    logic  pop_a_c, pop_b_c;

    // Ready depends only on the selected lane's registered fullness.
    always_comb begin
        sel_c    = lane_e'(in_sel);
        in_ready = (sel_c == LANE_A) ? !a_full : !b_full;
        push_a_c = in_valid && in_ready && (sel_c == LANE_A);
        push_b_c = in_valid && in_ready && (sel_c == LANE_B);
        pop_a_c  = a_ready && a_valid;
        pop_b_c  = b_ready && b_valid;
    end

    assign a_valid = !a_empty;
    assign b_valid = !b_empty;

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_a_c),
        .pop   (pop_a_c),
        .din   (in_data),
        .dout  (a_data),
        .full  (a_full),
        .empty (a_empty),
        .level (a_level)
    );

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_b_c),
        .pop   (pop_b_c),
        .din   (in_data),
        .dout  (b_data),
        .full  (b_full),
        .empty (b_empty),
        .level (b_level)
    );

endmodule : demux12bit_stream
